// File: rtl/lpc_residual_filter.sv
// -----------------------------------------------------------------------------
// lpc_residual_filter
//
// Order-10 LPC analysis (whitening) filter. For every accepted sample x[n]
// the block walks the external coefficient file one entry per cycle through a
// one-hot read select, accumulates the prediction p[n] = sum a_k * x[n-k]
// (k = 1..10) at full precision, then emits the saturated residual
// e[n] = x[n] - p[n] on a valid/ready stream. The 10-deep sample history is
// owned here and advances once per residual.
//
// Ports:
//   clk           clock, rising-edge
//   reset_n       asynchronous active-low reset
//   sample_in     signed input sample x[n]
//   sample_valid  sample_in is valid
//   sample_ready  block can accept a sample this cycle (state == IDLE)
//   hist_clr      synchronous history clear, honoured only in IDLE
//   coef_rsel     one-hot coefficient read select, bit k-1 selects a_k
//   coef_din      signed coefficient (COEF_FRAC fractional bits) for coef_rsel
//   res_out       signed saturated residual e[n]
//   res_valid     res_out is valid
//   res_ready     downstream accepts res_out
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a sample; hist_clr honoured here
// MAC   | 10 multiply-accumulate cycles, one coefficient per cycle
// OUT   | first cycle rounds/saturates and shifts history (res_pend),
//       | then holds res_out/res_valid until res_ready
// -----------------------------------------------------------------------------
module lpc_residual_filter #(
    parameter int SAMPLE_W  = 16,
    parameter int COEF_FRAC = 28,
    parameter int ACC_W     = 52
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                hist_clr,
    output logic [9:0]          coef_rsel,
    input  logic [31:0]         coef_din,
    output logic [SAMPLE_W-1:0] res_out,
    output logic                res_valid,
    input  logic                res_ready
);

    localparam int ORDER  = 10;
    localparam int PROD_W = 32 + SAMPLE_W;

    // Saturation bounds expressed at the ACC_W+1 difference width.
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W - SAMPLE_W + 2){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W - SAMPLE_W + 2){1'b1}}, {(SAMPLE_W - 1){1'b0}}};

    // Half an LSB of the integer prediction, for round-half-up.
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (COEF_FRAC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                     state;
    logic                       res_pend;
    logic [3:0]                 mac_step;
    logic signed [ACC_W-1:0]    acc;
    logic signed [SAMPLE_W-1:0] x_cur;
    // hist[i] holds x[n-1-i], i.e. hist[0] is the k=1 tap.
    logic signed [SAMPLE_W-1:0] hist [ORDER];

    logic signed [SAMPLE_W-1:0] hist_sel;
    logic signed [31:0]         coef_s;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W-1:0]    acc_rnd;
    logic signed [ACC_W-1:0]    pred;
    logic signed [ACC_W:0]      diff;
    logic signed [SAMPLE_W-1:0] res_sat;

    assign sample_ready = (state == IDLE);

    // The history tap follows the one-hot select, so the coefficient and
    // sample paired in a product always refer to the same k.
    always_comb begin
        hist_sel = '0;
        for (int i = 0; i < ORDER; i++) begin
            if (coef_rsel[i]) begin
                hist_sel = hist[i];
            end
        end
    end

    assign coef_s   = $signed(coef_din);
    assign prod     = coef_s * hist_sel;
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    assign acc_next = acc + prod_ext;

    assign acc_rnd = acc + RND_HALF;
    assign pred    = acc_rnd >>> COEF_FRAC;
    assign diff    = $signed({{(ACC_W + 1 - SAMPLE_W){x_cur[SAMPLE_W-1]}}, x_cur})
                   - $signed({pred[ACC_W-1], pred});

    always_comb begin
        res_sat = diff[SAMPLE_W-1:0];
        if (diff > SAT_MAX) begin
            res_sat = SAT_MAX[SAMPLE_W-1:0];
        end else if (diff < SAT_MIN) begin
            res_sat = SAT_MIN[SAMPLE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            res_pend  <= 1'b0;
            res_valid <= 1'b0;
            res_out   <= '0;
            coef_rsel <= '0;
            acc       <= '0;
            mac_step  <= '0;
            x_cur     <= '0;
            for (int i = 0; i < ORDER; i++) begin
                hist[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // A clear is applied before the accepted sample is
                    // processed, since MAC only reads history later.
                    if (hist_clr) begin
                        for (int i = 0; i < ORDER; i++) begin
                            hist[i] <= '0;
                        end
                    end
                    if (sample_valid) begin
                        x_cur     <= sample_in;
                        acc       <= '0;
                        coef_rsel <= 10'h001;
                        mac_step  <= '0;
                        state     <= MAC;
                    end
                end

                MAC: begin
                    acc <= acc_next;
                    if (mac_step == 4'd9) begin
                        coef_rsel <= '0;
                        mac_step  <= '0;
                        res_pend  <= 1'b1;
                        state     <= OUT;
                    end else begin
                        coef_rsel <= {coef_rsel[8:0], 1'b0};
                        mac_step  <= mac_step + 4'd1;
                    end
                end

                OUT: begin
                    if (res_pend) begin
                        res_pend  <= 1'b0;
                        res_out   <= res_sat;
                        res_valid <= 1'b1;
                        for (int i = ORDER - 1; i > 0; i--) begin
                            hist[i] <= hist[i-1];
                        end
                        hist[0] <= x_cur;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    coef_rsel <= '0;
                    res_valid <= 1'b0;
                    res_pend  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_residual_filter.sv
module tb_lpc_residual_filter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        hist_clr;
    logic [9:0]  coef_rsel;
    logic [31:0] coef_din;
    logic [15:0] res_out;
    logic        res_valid;
    logic        res_ready;

    logic [31:0] coef [10];

    int n_vec = 0;
    int n_err = 0;
    logic signed [15:0] exp_q [$];

    always #5 clk = ~clk;

    lpc_residual_filter #(.SAMPLE_W(16), .COEF_FRAC(28), .ACC_W(52)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .hist_clr     (hist_clr),
        .coef_rsel    (coef_rsel),
        .coef_din     (coef_din),
        .res_out      (res_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready)
    );

    // Coefficient register file model: combinational one-hot read.
    always_comb begin
        coef_din = '0;
        for (int i = 0; i < 10; i++) begin
            if (coef_rsel[i]) coef_din = coef[i];
        end
    end

    // Monitor: every completed output handshake is compared with the oldest
    // expected residual.
    always @(negedge clk) begin
        logic signed [15:0] e;
        if (reset_n && res_valid && res_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL res_unexpected: got %0d, none expected", $signed(res_out));
            end else begin
                e = exp_q.pop_front();
                if ($signed(res_out) !== e) begin
                    n_err++;
                    $display("FAIL residual: got %0d, expected %0d", $signed(res_out), e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_coefs(input logic [31:0] a1, input bit rnd_rest);
        coef[0] = a1;
        for (int i = 1; i < 10; i++) coef[i] = rnd_rest ? $urandom : 32'h0;
    endtask

    // All main-thread tasks are entered and left at posedge + 1.
    task automatic send(input logic signed [15:0] x, input logic signed [15:0] e, input bit clr);
        bit ok = 0;
        exp_q.push_back(e);
        sample_in    = x;
        sample_valid = 1'b1;
        hist_clr     = clr;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sample_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        hist_clr     = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got sample_ready=0, expected 1");
        end
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !res_valid) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic clear_hist();
        hist_clr = 1'b1;
        @(posedge clk);
        #1;
        hist_clr = 1'b0;
    endtask

    initial begin
        logic [15:0] held;
        bit seen;
        reset_n      = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        hist_clr     = 1'b0;
        res_ready    = 1'b1;
        set_coefs($urandom, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sample_ready", 32'(sample_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_coef_rsel", 32'(coef_rsel), 32'd0);
        chk("rst_res_out", 32'(res_out), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset in MAC cycle 5, sample is abandoned (no expected entry).
        sample_in = 16'd1234;
        sample_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sample_ready) break;
        end
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mac5_coef_rsel", 32'(coef_rsel), 32'h010);
        reset_n = 1'b0;
        #1;
        chk("midrst_sample_ready", 32'(sample_ready), 32'd1);
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_coef_rsel", 32'(coef_rsel), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send(16'sd1000, 16'sd1000, 0);
        drain();

        // Sequencing, with a clear coinciding with the accept.
        set_coefs($urandom, 1);
        send(-16'sd777, -16'sd777, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("seq_coef_rsel", 32'(coef_rsel), 32'(10'h001 << i));
            chk("seq_sample_ready", 32'(sample_ready), 32'd0);
            chk("seq_res_valid_early", 32'(res_valid), 32'd0);
        end
        @(negedge clk);
        chk("seq_coef_rsel_end", 32'(coef_rsel), 32'd0);
        chk("seq_res_valid_t10", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("seq_res_valid_t11", 32'(res_valid), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // First-order predictor a1 = 1.0.
        clear_hist();
        set_coefs(32'h1000_0000, 0);
        send(16'sd100, 16'sd100, 0);
        send(16'sd250, 16'sd150, 0);
        send(-16'sd50, -16'sd300, 0);
        drain();

        // Rounding with a1 = 0.5.
        clear_hist();
        set_coefs(32'h0800_0000, 0);
        send(16'sd3, 16'sd3, 0);
        send(16'sd10, 16'sd8, 0);
        drain();
        clear_hist();
        send(-16'sd3, -16'sd3, 0);
        send(16'sd0, 16'sd1, 0);
        drain();

        // Saturation with a1 = -1.0.
        clear_hist();
        set_coefs(32'hF000_0000, 0);
        send(16'sd30000, 16'sd30000, 0);
        send(16'sd30000, 16'sd32767, 0);
        drain();
        clear_hist();
        send(-16'sd30000, -16'sd30000, 0);
        send(-16'sd30000, -16'sd32768, 0);
        drain();

        // Backpressure: residual held 5 cycles while the next sample waits.
        clear_hist();
        set_coefs(32'h1000_0000, 0);
        res_ready = 1'b0;
        send(16'sd500, 16'sd500, 0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (res_valid) begin
                seen = 1;
                break;
            end
        end
        chk("bp_res_valid_seen", 32'(seen), 32'd1);
        held = res_out;
        sample_in = 16'sd200;
        sample_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_res_out_stable", 32'(res_out), 32'(held));
            chk("bp_res_valid_held", 32'(res_valid), 32'd1);
            chk("bp_sample_ready", 32'(sample_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        send(16'sd200, -16'sd300, 0);
        drain();

        // History clear in IDLE.
        send(16'sd500, 16'sd300, 0);
        drain();
        clear_hist();
        send(16'sd200, 16'sd200, 0);
        drain();

        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
